// File: rtl/rle_video_pkg.sv
// rle_video_pkg: shared token, state and helper definitions for the RLE video decoder
package rle_video_pkg;
  localparam int RLE_RUN_W = 10;
  localparam int RLE_COL_W = 6;
  localparam int RLE_FIFO_DEPTH = 4;
  localparam int RLE_REP_W = 2;
  typedef struct packed {
    logic [RLE_RUN_W-1:0] run;
    logic [RLE_COL_W-1:0] colour;
  } rle_token_t;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, STARVE} state_t;
  // End-of-stream is a run field of all ones, for any run width up to 31
  function automatic logic is_eos(input logic [31:0] run, input int w);
    return run == (32'd1 << w) - 32'd1;
  endfunction
endpackage

// File: rtl/rle_token_fifo.sv
// rle_token_fifo: synchronous token FIFO with flush and occupancy count
module rle_token_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  assign o_full = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign o_dout = r_mem[r_rp];
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  // Storage write; a flush drops any push in the same cycle
  always_ff @(posedge clk)
    if (w_push && !i_flush) r_mem[r_wp] <= i_din;
  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/rle_video_fifo.sv
// rle_video_fifo: run-length video decoder with prefetch FIFO, frame repeat and underflow flag
module rle_video_fifo
  import rle_video_pkg::*;
#(
  parameter int RUN_W = RLE_RUN_W,
  parameter int COL_W = RLE_COL_W,
  parameter int FIFO_DEPTH = RLE_FIFO_DEPTH,
  parameter int REP_W = RLE_REP_W,
  localparam int TW = RUN_W + COL_W,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_data_valid,
  output logic             o_data_ready,
  input  logic [TW-1:0]    i_data,
  input  logic             i_next_frame,
  input  logic             i_next_pixel,
  input  logic [REP_W-1:0] i_repeat_count,
  output logic [COL_W-1:0] o_colour,
  output logic             o_save_addr,
  output logic             o_load_addr,
  output logic             o_clear_addr,
  output logic [CW-1:0]    o_addr_backoff,
  output logic             o_underflow
);
  state_t r_state;
  logic [RUN_W-1:0] r_rem;
  logic [REP_W-1:0] r_rep;
  logic [COL_W-1:0] r_colour;
  logic r_save, r_load, r_clear, r_underflow;
  logic [CW-1:0] r_backoff;
  logic [TW-1:0] w_dout;
  logic [RUN_W-1:0] w_run;
  logic [CW-1:0] w_count;
  logic w_full, w_empty, w_nf, w_rep, w_last, w_pop, w_eos, w_flush, w_push;
  assign w_run = w_dout[TW-1:COL_W];
  assign w_nf = i_next_frame && r_state != IDLE;
  assign w_rep = w_nf && r_rep < i_repeat_count;
  assign w_last = i_next_pixel && r_rem == RUN_W'(1);
  assign w_pop = !w_nf && !w_empty &&
                 (r_state == LOAD || r_state == STARVE || (r_state == RUN && w_last));
  assign w_eos = w_pop && is_eos(32'(w_run), RUN_W);
  assign w_flush = w_rep || w_eos;
  assign o_data_ready = !w_full && !w_flush;
  assign w_push = i_data_valid && o_data_ready;
  assign o_colour = r_colour;
  assign o_save_addr = r_save;
  assign o_load_addr = r_load;
  assign o_clear_addr = r_clear;
  assign o_addr_backoff = r_backoff;
  assign o_underflow = r_underflow;
  rle_token_fifo #(.W(TW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .i_push(w_push), .i_pop(w_pop), .i_flush(w_flush),
    .i_din(i_data), .o_dout(w_dout), .o_full(w_full), .o_empty(w_empty), .o_count(w_count)
  );
  // Decoder FSM: frame start has priority over token pops, which have priority over pixel counting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem <= '0;
      r_rep <= '0;
      r_colour <= '0;
      r_save <= 1'b0;
      r_load <= 1'b0;
      r_clear <= 1'b0;
      r_underflow <= 1'b0;
      r_backoff <= '0;
    end else begin
      r_save <= 1'b0;
      r_load <= 1'b0;
      r_clear <= 1'b0;
      if (i_next_frame) r_underflow <= 1'b0;
      if (r_state == IDLE) begin
        if (i_next_frame) r_state <= LOAD;
      end else if (w_nf) begin
        r_state <= LOAD;
        r_colour <= '0;
        r_rem <= '0;
        if (w_rep) begin
          r_load <= 1'b1;
          r_rep <= r_rep + 1'b1;
        end else begin
          r_save <= 1'b1;
          r_backoff <= w_count + CW'(w_push);
          r_rep <= '0;
        end
      end else if (w_pop) begin
        if (w_eos) begin
          r_clear <= 1'b1;
          r_rep <= '0;
          r_colour <= '0;
          r_state <= IDLE;
        end else if (w_run == '0) begin
          if (r_state == RUN) r_state <= LOAD;
        end else begin
          r_rem <= w_run;
          r_colour <= w_dout[COL_W-1:0];
          r_state <= RUN;
        end
      end else if (r_state == RUN && i_next_pixel) begin
        if (r_rem == RUN_W'(1)) begin
          r_colour <= '0;
          r_underflow <= 1'b1;
          r_rem <= '0;
          r_state <= STARVE;
        end else r_rem <= r_rem - 1'b1;
      end
    end
  end
endmodule
